// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage CPU pipeline control.
package cpu_pkg;
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Clrn,
    input  logic          Inc,
    output logic [CW-1:0] Q
);
    logic [CW-1:0] cnt_q;

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn)
            cnt_q <= '0;
        else if (Inc && (cnt_q != '1))
            cnt_q <= cnt_q + 1'b1;
    end

    assign Q = cnt_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing: load-use stalls, MEM-stage redirects and halt/resume,
// driving PC/IF enables and the pipeline-register flushes directly.
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int LU_STALL = 1,
    parameter int CW       = 16
) (
    input  logic          Clk,
    input  logic          Clrn,
    input  logic [4:0]    ID_Rs,
    input  logic [4:0]    ID_Rt,
    input  logic          ID_UsesRt,
    input  logic          ID_Halt,
    input  logic          EX_MemRead,
    input  logic [4:0]    EX_Rt,
    input  logic          MEM_PCSrc,
    input  logic          Resume,
    output logic          PC_En,
    output logic          IFID_En,
    output logic          IFID_Flush,
    output logic          IDEX_Flush,
    output logic          EXMEM_Flush,
    output logic          Halted,
    output logic [CW-1:0] Stall_Cnt,
    output logic [CW-1:0] Flush_Cnt
);
    localparam logic [1:0] REM_INIT = 2'(LU_STALL - 1);

    hz_state_e  state_q, state_d;
    logic [1:0] rem_q, rem_d;
    logic       lu, redir, hold;
    logic       stall_inc, flush_inc;

    assign lu = EX_MemRead && (EX_Rt != REG_ZERO) &&
                ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q <= RUN;
            rem_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // redir: flush all three registers and let the target load.
    // hold: freeze PC and IF/ID, inject a bubble into ID/EX.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        redir     = 1'b0;
        hold      = 1'b0;
        stall_inc = 1'b0;
        case (state_q)
            RUN: begin
                if (MEM_PCSrc) begin
                    redir = 1'b1;
                end else if (lu) begin
                    hold      = 1'b1;
                    stall_inc = 1'b1;
                    if (LU_STALL > 1) begin
                        state_d = STALL;
                        rem_d   = REM_INIT;
                    end
                end else if (ID_Halt) begin
                    hold    = 1'b1;
                    state_d = HALT;
                end
            end
            STALL: begin
                if (MEM_PCSrc) begin
                    redir   = 1'b1;
                    state_d = RUN;
                    rem_d   = 2'd0;
                end else begin
                    hold      = 1'b1;
                    stall_inc = 1'b1;
                    rem_d     = rem_q - 2'd1;
                    if (rem_q <= 2'd1)
                        state_d = RUN;
                end
            end
            HALT: begin
                if (MEM_PCSrc) begin
                    redir   = 1'b1;
                    state_d = RUN;
                end else begin
                    hold = 1'b1;
                    if (Resume)
                        state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign flush_inc = redir;

    // Reset overrides everything so the pipeline registers fill with bubbles.
    assign PC_En       = Clrn & ~hold;
    assign IFID_En     = Clrn & ~hold;
    assign IFID_Flush  = ~Clrn | redir;
    assign IDEX_Flush  = ~Clrn | redir | hold;
    assign EXMEM_Flush = ~Clrn | redir;
    assign Halted      = Clrn & (state_q == HALT);

    sat_counter #(.CW(CW)) u_stall_cnt (
        .Clk  (Clk),
        .Clrn (Clrn),
        .Inc  (stall_inc),
        .Q    (Stall_Cnt)
    );

    sat_counter #(.CW(CW)) u_flush_cnt (
        .Clk  (Clk),
        .Clrn (Clrn),
        .Inc  (flush_inc),
        .Q    (Flush_Cnt)
    );
endmodule
